// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall control logic.
// Holds the stall FSM encoding, the zero-register constant and the default counter width.
package cpu_pipe_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_t;

    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int         CNT_W_DEFAULT = 16;

    // Load-use hazard: a load in EX writes a register that the instruction in ID reads.
    // $zero is never a real dependency.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter that sticks at all-ones instead of wrapping.
// It shares the pipeline's falling-edge timing and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline-register enable/flush sequencing for the 5-stage core: load-use bubbles,
// branch/jump flushes, a memory-busy freeze and saturating stall/flush counters.
module hazard_stall_controller
    import cpu_pipe_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic             ID_Jump,
    input  logic             MEM_BranchTaken,
    input  logic             MemBusy,
    output logic             PC_enable,
    output logic             IF_ID_enable,
    output logic             IF_ID_flush,
    output logic             ID_EX_enable,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             EX_MEM_enable,
    output logic             MEM_WB_enable,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    // Bubble count is held in 3 bits, so LOAD_STALL_CYCLES must stay within 1..7.
    localparam logic [2:0] LAST_BUBBLE = 3'(LOAD_STALL_CYCLES - 1);

    stall_state_t state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         hazard;
    logic         stall_inc;
    logic         flush_inc;

    assign hazard = load_use_hazard(EX_MemRead, EX_Rt, ID_Rs, ID_Rt, ID_UsesRt);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        PC_enable     = 1'b1;
        IF_ID_enable  = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_enable  = 1'b1;
        ID_EX_flush   = 1'b0;
        EX_MEM_flush  = 1'b0;
        EX_MEM_enable = 1'b1;
        MEM_WB_enable = 1'b1;

        // Under reset the pipeline registers clear themselves; outputs stay at the idle pattern.
        if (!reset) begin
            state_d = RUN;
            cnt_d   = 3'd0;
        end else if (MemBusy) begin
            // Whole pipe frozen, including MEM, so a taken branch waits to be seen again.
            PC_enable     = 1'b0;
            IF_ID_enable  = 1'b0;
            ID_EX_enable  = 1'b0;
            EX_MEM_enable = 1'b0;
            MEM_WB_enable = 1'b0;
        end else if (MEM_BranchTaken) begin
            // The branch is older than any stalled load, so it cancels the bubble sequence.
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            flush_inc    = 1'b1;
            state_d      = RUN;
            cnt_d        = 3'd0;
        end else if (state_q == STALL) begin
            PC_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            ID_EX_flush  = 1'b1;
            stall_inc    = 1'b1;
            if (cnt_q == LAST_BUBBLE) begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (hazard) begin
            PC_enable    = 1'b0;
            IF_ID_enable = 1'b0;
            ID_EX_flush  = 1'b1;
            stall_inc    = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = STALL;
                cnt_d   = 3'd1;
            end
        end else if (ID_Jump) begin
            IF_ID_flush = 1'b1;
            flush_inc   = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (FlushCount)
    );

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences the pipeline-register enables and flushes of the 5-stage MIPS core: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Detects load-use hazards and inserts a configurable number of bubbles into ID/EX.
- Flushes younger stages on a taken branch or jump, and freezes the whole pipeline while data memory is busy.
- Keeps saturating stall and flush performance counters.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; state updates on the falling edge, the same edge the pipeline registers use.
- reset  in  1  asynchronous, active-low.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as a source.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_Rt  in  5  destination (rt) of the load in EX.
- ID_Jump  in  1  jump or jal decoded in ID.
- MEM_BranchTaken  in  1  branch resolved taken in MEM.
- MemBusy  in  1  data memory not ready.
- PC_enable  out  1  PC update enable.
- IF_ID_enable  out  1  IF/ID enable.
- IF_ID_flush  out  1  zero the IF/ID instruction.
- ID_EX_enable  out  1  ID/EX enable.
- ID_EX_flush  out  1  select zero controls into ID/EX (bubble).
- EX_MEM_flush  out  1  zero EX/MEM controls.
- EX_MEM_enable  out  1  EX/MEM enable.
- MEM_WB_enable  out  1  MEM/WB enable.
- StallCycles  out  CNT_W  saturating count of load-use bubble cycles.
- FlushCount  out  CNT_W  saturating count of branch/jump flush events.

Behaviour:
- State is a 2-state FSM (RUN, STALL) plus a 3-bit bubble counter `cnt`.
- Outputs are combinational from state, `cnt` and inputs. Only the FSM, `cnt` and the counters are registered.
- Reset (reset=0, async): state=RUN, cnt=0, StallCycles=0, FlushCount=0.
- While reset is held, all enables read 1 and all flushes read 0. The pipeline registers are themselves held in reset.
- hazard = EX_MemRead & (EX_Rt!=0) & ((EX_Rt==ID_Rs) | (ID_UsesRt & EX_Rt==ID_Rt)).
- Output priority, evaluated each cycle:
  1. MemBusy=1: every enable=0 and every flush=0. FSM, cnt and counters hold. A pending MEM_BranchTaken is not consumed, because MEM is frozen.
  2. MEM_BranchTaken=1: all enables=1; IF_ID_flush=1, ID_EX_flush=1, EX_MEM_flush=1. Next state=RUN, cnt=0, FlushCount+1. This aborts any STALL, because the branch is older than the load.
  3. STALL state: PC_enable=0, IF_ID_enable=0, ID_EX_flush=1, other enables=1, StallCycles+1.
     - When cnt==LOAD_STALL_CYCLES-1, the next state is RUN with cnt=0; otherwise cnt+1.
     - ID_Jump is ignored while in STALL.
  4. RUN with hazard: same outputs as STALL, StallCycles+1. If LOAD_STALL_CYCLES==1 stay in RUN; else go to STALL with cnt=1.
  5. RUN with ID_Jump: all enables=1, IF_ID_flush=1, FlushCount+1.
  6. Otherwise: all enables=1, flushes=0.
- Latency: a hazard or flush takes effect in the same cycle the input is seen, with zero registered delay.
- A load-use bubble costs exactly LOAD_STALL_CYCLES cycles.
- Counters saturate at all-ones and never wrap.
- A hazard re-detected on the cycle STALL returns to RUN starts a new stall; this is legal for back-to-back loads.
- Reset asserted mid-STALL returns to RUN immediately. No partial bubble survives.

Decomposition:
- Shared package cpu_pipe_pkg holds the FSM state encoding (RUN=1'b0, STALL=1'b1), the zero-register constant REG_ZERO=5'd0 and the default CNT_W.
- One sub-module, sat_counter (parameter W; inc, clk, reset), is instantiated twice for StallCycles and FlushCount.

Test Plan:
1. Load-use on rs: EX_MemRead=1, EX_Rt=5, ID_Rs=5, LOAD_STALL_CYCLES=1 -> one cycle with PC_enable=0, IF_ID_enable=0, ID_EX_flush=1; next cycle all enables=1; StallCycles=1.
2. Load-use with LOAD_STALL_CYCLES=3, hazard held constant -> exactly 3 bubble cycles, then RUN; StallCycles=3. Repeat with EX_Rt=0 -> no stall.
3. MEM_BranchTaken=1 in the 2nd cycle of a 3-cycle STALL -> that cycle all enables=1, all three flushes=1; next cycle RUN with no further bubble; FlushCount=1, StallCycles=1.
4. MemBusy=1 for 4 cycles during STALL cnt=1 -> all enables=0 for 4 cycles, cnt stays 1; after release the stall completes with 2 remaining bubbles.
5. ID_Jump=1 with hazard=1 at the same time -> stall outputs win, no IF_ID_flush; the jump flushes on the cycle after the stall ends; FlushCount=1.
6. Force StallCycles to 16'hFFFE, then 3 hazard cycles -> reads 16'hFFFF and holds. Async reset mid-STALL -> RUN, counters 0, with no clock edge needed.
